// File: rtl/benzaiten_mem_pkg.sv
// Shared types and constants for the word-memory load/store path.
//   mem_size_e  : access size encoding carried on req_size
//   lsu_state_e : mem_lsu sequencer states
//   MEM_RD/WR   : mem_rw encodings (memory writes whenever mem_rw = MEM_WR)
//   natural_off : byte offset forced to the natural alignment of a size
package benzaiten_mem_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'd0,
    SZ_H   = 2'd1,
    SZ_W   = 2'd2,
    SZ_RSV = 2'd3
  } mem_size_e;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StRdw,
    StWr,
    StResp
  } lsu_state_e;

  localparam logic MEM_RD = 1'b1;
  localparam logic MEM_WR = 1'b0;

  // Clears the low offset bits that a size of this width cannot legally use.
  function automatic logic [1:0] natural_off(mem_size_e size, logic [1:0] off);
    logic [1:0] res;
    res = off;
    case (size)
      SZ_B:    res = off;
      SZ_H:    res = {off[1], 1'b0};
      default: res = 2'b00;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic between a 32-bit little-endian memory word and
// a byte/half/word access.
//   size, off     : access size and byte offset within the word
//   uns           : zero-extend loads when 1, sign-extend when 0
//   rdata         : word read from memory
//   wdata         : right-aligned store data
//   misaligned    : offset illegal for size, or reserved size
//   load_data     : selected lane, extended to 32 bits
//   store_data    : rdata with the addressed lane replaced by wdata
module mem_lane_align
  import benzaiten_mem_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  mem_size_e        size,
  input  logic [1:0]       off,
  input  logic             uns,
  input  logic [XLEN-1:0]  rdata,
  input  logic [XLEN-1:0]  wdata,
  output logic             misaligned,
  output logic [XLEN-1:0]  load_data,
  output logic [XLEN-1:0]  store_data
);

  logic [4:0]      shamt;
  logic [XLEN-1:0] lane;
  logic [XLEN-1:0] mask;

  assign shamt = {off, 3'b000};
  assign lane  = rdata >> shamt;

  always_comb begin
    misaligned = 1'b0;
    load_data  = rdata;
    store_data = wdata;
    mask       = '0;
    case (size)
      SZ_B: begin
        load_data  = {{24{~uns & lane[7]}}, lane[7:0]};
        mask       = 32'h0000_00ff << shamt;
        store_data = (rdata & ~mask) | ({24'b0, wdata[7:0]} << shamt);
      end
      SZ_H: begin
        misaligned = off[0];
        load_data  = {{16{~uns & lane[15]}}, lane[15:0]};
        mask       = 32'h0000_ffff << shamt;
        store_data = (rdata & ~mask) | ({16'b0, wdata[15:0]} << shamt);
      end
      SZ_W: begin
        misaligned = (off != 2'b00);
        load_data  = rdata;
        store_data = wdata;
      end
      default: begin
        misaligned = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store master for a single-port registered word memory. Turns one
// byte/half/word request at a time into word read, read-modify-write or write
// cycles and returns a one-cycle response pulse.
//   clk, rst_n              : clock, asynchronous active-low reset
//   req_valid/req_ready     : request handshake (accept on valid && ready)
//   req_we/size/unsigned    : store flag, access size, load zero-extension
//   req_addr/req_wdata      : byte address, right-aligned store data
//   resp_valid              : one-cycle completion pulse
//   resp_rdata/resp_err     : extended load data / misalignment flag, held
//   mem_addr/mem_val/mem_rw : word address, write data, 1 = read 0 = write
//   mem_res                 : memory read data, one cycle after a read edge
module mem_lsu
  import benzaiten_mem_pkg::*;
#(
  parameter int unsigned XLEN          = 32,
  parameter bit          MISALIGN_TRAP = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_val,
  output logic            mem_rw,
  input  logic [XLEN-1:0] mem_res
);

  lsu_state_e      state;
  logic            lat_we;
  mem_size_e       lat_size;
  logic            lat_uns;
  logic [1:0]      lat_off;
  logic [XLEN-1:0] lat_wdata;

  mem_size_e       acc_size;
  mem_size_e       al_size;
  logic [1:0]      al_off;
  logic            misaligned;
  logic            trap;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] store_data;

  assign acc_size = mem_size_e'(req_size);

  // The lane unit checks the incoming request while idle and works on the
  // latched access afterwards.
  assign al_size = (state == StIdle) ? acc_size : lat_size;
  assign al_off  = (state == StIdle) ? req_addr[1:0] : lat_off;

  // A reserved size has no sensible alignment to force, so it always traps.
  assign trap = misaligned && (MISALIGN_TRAP || (acc_size == SZ_RSV));

  mem_lane_align #(
    .XLEN(XLEN)
  ) u_align (
    .size      (al_size),
    .off       (al_off),
    .uns       (lat_uns),
    .rdata     (mem_res),
    .wdata     (lat_wdata),
    .misaligned(misaligned),
    .load_data (load_data),
    .store_data(store_data)
  );

  // Handshake and memory control are decoded from state alone, so a reset
  // drops a pending write immediately.
  assign req_ready  = (state == StIdle);
  assign resp_valid = (state == StResp);
  assign mem_rw     = (state == StWr) ? MEM_WR : MEM_RD;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= StIdle;
      lat_we     <= 1'b0;
      lat_size   <= SZ_B;
      lat_uns    <= 1'b0;
      lat_off    <= 2'b00;
      lat_wdata  <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_addr   <= '0;
      mem_val    <= '0;
    end else begin
      case (state)
        StIdle: begin
          if (req_valid) begin
            lat_we    <= req_we;
            lat_size  <= acc_size;
            lat_uns   <= req_unsigned;
            lat_off   <= natural_off(acc_size, req_addr[1:0]);
            lat_wdata <= req_wdata;
            mem_addr  <= {req_addr[XLEN-1:2], 2'b00};
            if (trap) begin
              resp_rdata <= '0;
              resp_err   <= 1'b1;
              state      <= StResp;
            end else if (req_we && (acc_size == SZ_W)) begin
              mem_val <= req_wdata;
              state   <= StWr;
            end else begin
              state <= StRd;
            end
          end
        end
        StRd: state <= StRdw;
        StRdw: begin
          if (lat_we) begin
            mem_val <= store_data;
            state   <= StWr;
          end else begin
            resp_rdata <= load_data;
            resp_err   <= 1'b0;
            state      <= StResp;
          end
        end
        StWr: begin
          resp_rdata <= '0;
          resp_err   <= 1'b0;
          state      <= StResp;
        end
        StResp:  state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
module tb_mem_lsu;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_val;
  logic        mem_rw;
  logic [31:0] mem_res;

  int checks = 0;
  int errors = 0;
  int tx_cnt = 0;

  // Bus-side memory (16 words, aliased on addr[5:2]) and its monitors.
  logic [31:0] mem      [16];
  logic [31:0] init_mem [16];
  logic [31:0] shadow   [16];
  logic        load_mem;
  int          wr_cnt      = 0;
  int          resp_pulses = 0;
  logic [31:0] last_wval   = '0;

  mem_lsu dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .mem_addr    (mem_addr),
    .mem_val     (mem_val),
    .mem_rw      (mem_rw),
    .mem_res     (mem_res)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_mem[i];
    end else if (mem_rw == 1'b0) begin
      mem[mem_addr[5:2]] <= mem_val;
      wr_cnt             <= wr_cnt + 1;
      last_wval          <= mem_val;
    end
    mem_res <= mem[mem_addr[5:2]];
    if (resp_valid) resp_pulses <= resp_pulses + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_mis(input logic [1:0] size, input logic [31:0] addr);
    return (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00);
  endfunction

  // Issues one request (called at a negedge) and checks its response against
  // a byte-level model of the access. keep leaves req_valid high afterwards.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input bit keep);
    int          exp_lat;
    int          exp_wr;
    int          got;
    int          guard;
    int          busy_ready;
    int          wr0;
    int          idx;
    int          off;
    int          nb;
    logic        exp_err;
    logic [31:0] exp_rd;
    logic [31:0] word;
    logic [31:0] nword;
    logic [31:0] v;
    logic [31:0] m;
    idx     = int'(addr[5:2]);
    off     = int'(addr[1:0]);
    nb      = 1 << size;
    word    = shadow[idx];
    nword   = word;
    exp_rd  = '0;
    exp_err = 1'b0;
    exp_wr  = 0;
    if (is_mis(size, addr)) begin
      exp_lat = 1;
      exp_err = 1'b1;
    end else if (we) begin
      for (int i = 0; i < nb; i++) begin
        m     = 32'hff << (8 * (off + i));
        nword = (nword & ~m) | (((wdata >> (8 * i)) & 32'hff) << (8 * (off + i)));
      end
      exp_wr  = 1;
      exp_lat = (size == 2'd2) ? 2 : 4;
    end else begin
      v = '0;
      for (int i = 0; i < nb; i++) v |= ((word >> (8 * (off + i))) & 32'hff) << (8 * i);
      if (!uns && nb < 4 && v[8 * nb - 1]) v |= ~((32'h1 << (8 * nb)) - 1);
      exp_rd  = v;
      exp_lat = 3;
    end

    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    guard        = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) check("ready_timeout", 32'(req_ready), 32'd1);
    @(posedge clk);
    wr0        = wr_cnt;
    got        = 99;
    busy_ready = 0;
    for (int l = 1; l <= 8; l++) begin
      @(negedge clk);
      if (resp_valid) begin
        got = l;
        break;
      end
      if (req_ready) busy_ready++;
      // Junk on the request bus while busy must be ignored.
      req_we       = 1'($urandom);
      req_size     = 2'($urandom);
      req_unsigned = 1'($urandom);
      req_addr     = $urandom;
      req_wdata    = $urandom;
    end
    check("latency", 32'(got), 32'(exp_lat));
    check("resp_err", 32'(resp_err), 32'(exp_err));
    check("resp_rdata", resp_rdata, exp_rd);
    check("mem_addr", mem_addr, {addr[31:2], 2'b00});
    check("write_cycles", 32'(wr_cnt - wr0), 32'(exp_wr));
    check("ready_busy", 32'(busy_ready), 32'd0);
    if (exp_wr != 0) check("write_value", last_wval, nword);
    check("mem_word", mem[idx], nword);
    shadow[idx] = nword;
    tx_cnt++;
    if (!keep) req_valid = 1'b0;
  endtask

  initial begin
    int wr0;
    clk          = 1'b0;
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    load_mem     = 1'b1;
    for (int i = 0; i < 16; i++) init_mem[i] = $urandom;
    init_mem[0] = 32'h0000_beef;
    for (int i = 0; i < 16; i++) shadow[i] = init_mem[i];
    repeat (2) @(posedge clk);
    @(negedge clk);

    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", 32'(resp_err), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_val", mem_val, 32'd0);
    check("rst_mem_rw", 32'(mem_rw), 32'd1);
    load_mem = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);

    issue(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 1'b0);
    check("lw_beef", resp_rdata, 32'h0000_beef);
    issue(1'b0, 2'd0, 1'b0, 32'h1, 32'h0, 1'b1);
    check("lb_sext", resp_rdata, 32'hffff_ffbe);
    issue(1'b0, 2'd0, 1'b1, 32'h1, 32'h0, 1'b1);
    check("lbu_zext", resp_rdata, 32'h0000_00be);
    issue(1'b0, 2'd1, 1'b0, 32'h0, 32'h0, 1'b1);
    check("lh_sext", resp_rdata, 32'hffff_beef);
    issue(1'b0, 2'd1, 1'b1, 32'h0, 32'h0, 1'b1);
    check("lhu_zext", resp_rdata, 32'h0000_beef);
    issue(1'b1, 2'd0, 1'b0, 32'h2, 32'haaaa_aa12, 1'b1);
    check("sb_merge", last_wval, 32'h0012_beef);
    issue(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 1'b1);
    check("lw_after_sb", resp_rdata, 32'h0012_beef);
    issue(1'b1, 2'd2, 1'b0, 32'h8, 32'hdead_f00d, 1'b1);
    issue(1'b0, 2'd2, 1'b0, 32'h2, 32'h0, 1'b1);
    issue(1'b0, 2'd1, 1'b0, 32'h3, 32'h0, 1'b1);
    issue(1'b1, 2'd3, 1'b0, 32'h4, 32'h1234_5678, 1'b1);
    issue(1'b1, 2'd2, 1'b0, 32'hffff_fffc, 32'hcafe_babe, 1'b1);
    issue(1'b0, 2'd1, 1'b0, 32'hffff_fffe, 32'h0, 1'b0);
    check("lh_top", resp_rdata, 32'hffff_cafe);
    @(negedge clk);

    // Reset while a half-word store sits in its write cycle.
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 2'd1;
    req_addr  = 32'h4;
    req_wdata = 32'h0000_5555;
    check("rst_test_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("sh_in_wr", 32'(mem_rw), 32'd0);
    wr0   = wr_cnt;
    rst_n = 1'b0;
    #1;
    check("rst_mid_rw", 32'(mem_rw), 32'd1);
    check("rst_mid_resp", 32'(resp_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_mid_nowrite", 32'(wr_cnt - wr0), 32'd0);
    check("rst_mid_mem", mem[1], shadow[1]);
    check("rst_mid_ready", 32'(req_ready), 32'd1);
    @(negedge clk);

    for (int t = 0; t < 150; t++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      issue(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), a, $urandom,
            ($urandom_range(0, 3) != 0));
    end
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("resp_pulses", 32'(resp_pulses), 32'(tx_cnt));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
Load/store master that drives the single-port word memory (addr/val/rw → res) on behalf of the core's load/store stage.
- Converts byte/half/word loads and stores with a valid/ready request and a one-cycle response pulse into word-wide memory cycles.
- Performs sign/zero extension on loads.
- Performs read-modify-write for sub-word stores.
- Traps misaligned accesses without touching memory.

Parameters:
XLEN, 32, data and address width; only 32 is supported.
MISALIGN_TRAP, 1, 1 = misaligned access returns resp_err; 0 = low address bits are forced to natural alignment and the access proceeds.

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
req_valid  input  1  request present
req_ready  output  1  block can accept a request
req_we  input  1  1 = store, 0 = load
req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = reserved (treated as misaligned)
req_unsigned  input  1  load zero-extends when 1
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  load result, extended; 0 for stores and errors
resp_err  output  1  misaligned or reserved size, qualified by resp_valid
mem_addr  output  32  word address to memory
mem_val  output  32  write data to memory
mem_rw  output  1  1 = read, 0 = write; memory writes on every clk edge where mem_rw = 0
mem_res  input  32  read data, registered by memory, valid the cycle after a read edge

Behaviour:
- States: IDLE, RD, RDW, WR, RESP. All outputs are registered or decoded from state only.
- Reset (async): state = IDLE, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, mem_addr = 0, mem_val = 0, mem_rw = 1.
- mem_rw = 0 only in WR; 1 in every other state, including reset. This prevents spurious writes.
- req_ready = (state == IDLE). A request is accepted on an edge with req_valid && req_ready.
- On accept, latch we, size, unsigned, addr[1:0], wdata.
  - mem_addr = {req_addr[31:2], 2'b00}, held until the next accept.
  - Misaligned means half with addr[0] = 1, word with addr[1:0] != 0, or size 3.
- Transitions from IDLE:
  - Misaligned and MISALIGN_TRAP = 1 → RESP with err = 1.
  - Word store → WR, with mem_val = wdata.
  - All loads → RD.
  - Sub-word stores → RD.
- RD: mem_rw = 1, go to RDW. The memory captures res on this edge.
- RDW: sample mem_res.
  - Load: extract the lane at byte offset off = addr[1:0]; little-endian, so byte k = bits [8k+7:8k]. Extend, latch into resp_rdata, go to RESP.
  - Sub-word store: mem_val = mem_res with the byte/half lane replaced by wdata[7:0] / wdata[15:0], go to WR.
- WR: mem_rw = 0 for exactly one cycle, go to RESP.
- RESP: resp_valid = 1 for exactly one cycle, then IDLE. There is no response backpressure.
- resp_rdata and resp_err hold until the next RESP. resp_rdata = 0 for stores and errors.
- Latency from the accept edge to resp_valid high:
  - misaligned: 1 cycle
  - word store: 2 cycles
  - load: 3 cycles
  - sub-word store: 4 cycles
- Throughput: at most one request in flight. A new request is accepted the cycle after RESP, when IDLE is re-entered.
- req_valid held high during busy states: ignored, no side effects. Request inputs are don't-care outside the accept edge.
- Reset mid-operation: immediately IDLE, mem_rw = 1. A pending WR is abandoned (no write). No resp_valid is issued.
- Boundary at addr 32'hFFFF_FFFC: no wrap logic needed; the word address is simply the truncated address.

Decomposition:
- Package benzaiten_mem_pkg holds:
  - enum mem_size_e {SZ_B, SZ_H, SZ_W, SZ_RSV}
  - enum lsu_state_e
  - constants MEM_RD = 1'b1, MEM_WR = 1'b0
- One combinational sub-module, mem_lane_align, contains the misalign check, load extract/extend, and store merge. It is shared later with any cache fill path.

Test Plan:
Memory model word = 32'h0000_BEEF unless noted.
- LW addr 0x0 → resp_valid exactly 3 cycles after accept; rdata = 32'h0000_BEEF; err = 0; mem_rw never 0.
- LB addr 0x1 → rdata 32'hFFFF_FFBE. LBU addr 0x1 → 32'h0000_00BE. LH addr 0x0 → 32'hFFFF_BEEF. LHU addr 0x0 → 32'h0000_BEEF.
- SB wdata 32'hAAAA_AA12 addr 0x2 → exactly one mem_rw = 0 cycle with mem_val = 32'h0012_BEEF; resp 4 cycles after accept; a following LW returns 32'h0012_BEEF.
- SW wdata 32'hDEAD_F00D → single write cycle 1 cycle after accept; resp at 2 cycles; req_ready low for 2 cycles.
- LW addr 0x2, and LH addr 0x3 → resp_err = 1, rdata = 0, resp at 1 cycle, memory model sees no write.
- rst_n pulsed low during the WR of an SH → mem_rw = 1 immediately, memory unchanged, no resp_valid, req_ready = 1 after release; back-to-back requests with req_valid held high each complete in order.
